// File: rtl/tt_ctrl_sel.sv
// Pad-side select controller: synchronises the control pads, counts increment
// pulses into a {branch, module} address and commits it on enable. Optional
// increment glitch filter: define TT_CTRL_SEL_FILTER_EN.
//
// state  | meaning
// IDLE   | synchronised select-reset asserted, counter held at zero
// COUNT  | select-reset released, enable low, increments advance the counter
// ACTIVE | enable high, address committed, increments ignored
module tt_ctrl_sel #(
  parameter int N_BRANCH    = 24,
  parameter int N_UM        = 16,
  parameter int SYNC_STAGES = 2,
  localparam int BR_W = (N_BRANCH > 1) ? $clog2(N_BRANCH) : 1,
  localparam int UM_W = (N_UM > 1) ? $clog2(N_UM) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ctrl_sel_rst_n,
  input  logic                 ctrl_sel_inc,
  input  logic                 ctrl_ena,
  output logic [BR_W+UM_W-1:0] spine_addr,
  output logic                 spine_ena,
  output logic                 sel_overflow,
  output logic                 sel_busy
);

  localparam logic [BR_W-1:0] BR_LAST = BR_W'(N_BRANCH - 1);
  localparam logic [UM_W-1:0] UM_LAST = UM_W'(N_UM - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] rst_sync;
  logic [SYNC_STAGES-1:0] inc_sync;
  logic [SYNC_STAGES-1:0] ena_sync;
  logic                   s_rst_n;
  logic                   s_inc_raw;
  logic                   s_inc;
  logic                   s_ena;
  logic                   inc_d;
  logic                   ena_d;
  logic                   inc_p;
  logic                   ena_p;
  state_t                 state_q;
  state_t                 state_d;
  logic [BR_W-1:0]        cnt_br;
  logic [UM_W-1:0]        cnt_um;

  // Select-reset synchroniser idles high so a reset does not look like a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= '1;
      inc_sync <= '0;
      ena_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[SYNC_STAGES-2:0], ctrl_sel_rst_n};
      inc_sync <= {inc_sync[SYNC_STAGES-2:0], ctrl_sel_inc};
      ena_sync <= {ena_sync[SYNC_STAGES-2:0], ctrl_ena};
    end
  end

  assign s_rst_n   = rst_sync[SYNC_STAGES-1];
  assign s_inc_raw = inc_sync[SYNC_STAGES-1];
  assign s_ena     = ena_sync[SYNC_STAGES-1];

`ifdef TT_CTRL_SEL_FILTER_EN
  // The filtered level only moves once three consecutive samples agree;
  // otherwise it holds its previous value, which is inc_d.
  logic [1:0] inc_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inc_hist <= '0;
    else        inc_hist <= {inc_hist[0], s_inc_raw};
  end

  always_comb begin
    s_inc = inc_d;
    if (&{inc_hist, s_inc_raw})       s_inc = 1'b1;
    else if (~|{inc_hist, s_inc_raw}) s_inc = 1'b0;
  end
`else
  assign s_inc = s_inc_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_d <= 1'b0;
      ena_d <= 1'b0;
    end else begin
      inc_d <= s_inc;
      ena_d <= s_ena;
    end
  end

  assign inc_p = s_inc & ~inc_d;
  assign ena_p = s_ena & ~ena_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (s_rst_n) state_d = s_ena ? ACTIVE : COUNT;
      end
      COUNT: begin
        if (!s_rst_n)   state_d = IDLE;
        else if (s_ena) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!s_rst_n)    state_d = IDLE;
        else if (!s_ena) state_d = COUNT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counting uses the next state so an increment coinciding with the enable
  // rise is discarded and the pre-increment value gets committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_br       <= '0;
      cnt_um       <= '0;
      sel_overflow <= 1'b0;
    end else if (!s_rst_n) begin
      cnt_br       <= '0;
      cnt_um       <= '0;
      sel_overflow <= 1'b0;
    end else if (inc_p && (state_d == COUNT)) begin
      if (cnt_um < UM_LAST) begin
        cnt_um <= cnt_um + 1'b1;
      end else if (cnt_br < BR_LAST) begin
        cnt_um <= '0;
        cnt_br <= cnt_br + 1'b1;
      end else begin
        sel_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spine_addr <= '0;
      spine_ena  <= 1'b0;
      sel_busy   <= 1'b0;
    end else begin
      if (ena_p && (state_d == ACTIVE)) spine_addr <= {cnt_br, cnt_um};
      spine_ena <= (state_d == ACTIVE) & ~sel_overflow;
      sel_busy  <= ({cnt_br, cnt_um} != spine_addr);
    end
  end

endmodule
